// File: rtl/com_sys.sv
// com_sys: framed serial loopback (LFSR payload tx, channel, frame-sync rx).
// Ports:
//   clk_sys        in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   first_sequence out  [7:0] payload of transmitted frame 0
//   first_result   out  [7:0] payload of first frame received after lock
// Optional build macro: ERR_INJECT_EN (channel flips payload MSB of frame 0).
module com_sys #(
   parameter int         FREQ_DIV   = 128,
   parameter logic [5:0] HEADER     = 6'b100101,
   parameter logic [7:0] LFSR_SEED  = 8'hB4,
   parameter int         MISS_LIMIT = 3
) (
   input  logic       clk_sys,
   input  logic       reset,
   output logic [7:0] first_sequence,
   output logic [7:0] first_result
);

   localparam int CW = $clog2(FREQ_DIV);
   localparam int MW = $clog2(MISS_LIMIT + 1);

   localparam logic [1:0] SEARCH  = 2'd0;
   localparam logic [1:0] PAYLOAD = 2'd1;
   localparam logic [1:0] CHECK   = 2'd2;

   // bit timer
   logic [CW-1:0] div_cnt;
   logic          tx_tick;
   logic          rx_sample;

   assign tx_tick   = (div_cnt == CW'(FREQ_DIV - 1));
   assign rx_sample = (div_cnt == CW'(FREQ_DIV / 2 - 1));

   // transmitter
   logic [3:0]  bit_idx;
   logic [7:0]  lfsr;
   logic [7:0]  lfsr_next;
   logic [13:0] frame_word;
   logic        tx_line;
   logic        seq_done;

   assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign frame_word = {HEADER, lfsr};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         div_cnt        <= '0;
         bit_idx        <= '0;
         lfsr           <= LFSR_SEED;
         tx_line        <= 1'b0;
         seq_done       <= 1'b0;
         first_sequence <= 8'h00;
      end else begin
         div_cnt <= tx_tick ? '0 : div_cnt + CW'(1);
         if (tx_tick) begin
            // frame_word is MSB-first: index 13 goes out at bit_idx 0
            tx_line <= frame_word[4'd13 - bit_idx];
            if (bit_idx == 4'd13) begin
               bit_idx <= 4'd0;
               lfsr    <= lfsr_next;
            end else begin
               bit_idx <= bit_idx + 4'd1;
            end
            if (bit_idx == 4'd0 && !seq_done) begin
               first_sequence <= lfsr;
               seq_done       <= 1'b1;
            end
         end
      end
   end

   // channel
   logic rx_line;

`ifdef ERR_INJECT_EN
   logic frame0;
   logic flip;

   // flip is raised together with the payload MSB of frame 0 on tx_line
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         frame0 <= 1'b1;
         flip   <= 1'b0;
      end else if (tx_tick) begin
         flip <= frame0 && (bit_idx == 4'd6);
         if (bit_idx == 4'd13)
            frame0 <= 1'b0;
      end
   end

   assign rx_line = tx_line ^ flip;
`else
   assign rx_line = tx_line;
`endif

   // receiver
   logic [1:0]    state;
   logic [7:0]    shreg;
   logic [7:0]    sh_next;
   logic [2:0]    bit_cnt;
   logic [MW-1:0] miss_cnt;
   logic          result_done;

   assign sh_next = {shreg[6:0], rx_line};

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state        <= SEARCH;
         shreg        <= 8'h00;
         bit_cnt      <= 3'd0;
         miss_cnt     <= '0;
         result_done  <= 1'b0;
         first_result <= 8'h00;
      end else if (rx_sample) begin
         shreg <= sh_next;
         unique case (state)
            SEARCH: begin
               if (sh_next[5:0] == HEADER) begin
                  state   <= PAYLOAD;
                  bit_cnt <= 3'd0;
               end
            end
            PAYLOAD: begin
               if (bit_cnt == 3'd7) begin
                  bit_cnt <= 3'd0;
                  state   <= CHECK;
                  if (!result_done) begin
                     first_result <= sh_next;
                     result_done  <= 1'b1;
                  end
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            CHECK: begin
               if (bit_cnt == 3'd5) begin
                  bit_cnt <= 3'd0;
                  state   <= PAYLOAD;
                  if (sh_next[5:0] == HEADER) begin
                     miss_cnt <= '0;
                  end else if (miss_cnt == MW'(MISS_LIMIT - 1)) begin
                     miss_cnt <= '0;
                     state    <= SEARCH;
                  end else begin
                     miss_cnt <= miss_cnt + MW'(1);
                  end
               end else begin
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
            default: state <= SEARCH;
         endcase
      end
   end

endmodule

// File: tb/tb_com_sys.sv
// tb_com_sys: directed checks of com_sys at FREQ_DIV 128 and 8.
// Covers reset, capture timing, hold, mid-run reset and lock loss/relock.
module tb_com_sys;

   logic       clk;
   logic       reset;
   logic [7:0] first_sequence;
   logic [7:0] first_result;
   logic [7:0] fast_sequence;
   logic [7:0] fast_result;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

`ifdef ERR_INJECT_EN
   localparam logic [7:0] EXP_RES = 8'h34;
`else
   localparam logic [7:0] EXP_RES = 8'hB4;
`endif

   com_sys dut (
      .clk_sys        (clk),
      .reset          (reset),
      .first_sequence (first_sequence),
      .first_result   (first_result)
   );

   com_sys #(.FREQ_DIV(8)) dut_fast (
      .clk_sys        (clk),
      .reset          (reset),
      .first_sequence (fast_sequence),
      .first_result   (fast_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      cyc = 0;
   endtask

   // observe values present at edge c (edges 0..c-1 have occurred)
   task automatic goto(input int c);
      repeat (c - cyc) @(posedge clk);
      cyc = c;
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1;

      do_reset();
      check("rst_seq", first_sequence, 8'h00);
      check("rst_res", first_result, 8'h00);

      goto(115);
      check("fast_res_115", fast_result, 8'h00);
      goto(116);
      check("fast_res_116", fast_result, EXP_RES);
      check("fast_seq_116", fast_sequence, 8'hB4);

      goto(127);
      check("seq_127", first_sequence, 8'h00);
      check("res_127", first_result, 8'h00);
      goto(128);
      check("seq_128", first_sequence, 8'hB4);

      goto(1855);
      check("res_1855", first_result, 8'h00);
      goto(1856);
      check("res_1856", first_result, EXP_RES);

      goto(5000);
      check("res_5000", first_result, EXP_RES);
      check("seq_5000", first_sequence, 8'hB4);
      check("fast_res_5000", fast_result, EXP_RES);

      // kill the line: three failed header checks must drop lock
      force dut.rx_line = 1'b0;
      n = 0;
      while (dut.state != 2'd0 && n < 4 * 14 * 128) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("lock_drop", {6'd0, dut.state}, 8'h00);
      check("drop_late", (n > 2 * 14 * 128 - 128) ? 8'h01 : 8'h00,
            8'h01);
      release dut.rx_line;
      n = 0;
      while (dut.state != 2'd1 && n < 2 * 14 * 128 + 256) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("relock", {6'd0, dut.state}, 8'h01);
      check("res_after_relock", first_result, EXP_RES);
      check("seq_after_relock", first_sequence, 8'hB4);

      // reset pulse at cycle 1000
      do_reset();
      goto(1000);
      check("pre_pulse_seq", first_sequence, 8'hB4);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      cyc = 0;
      check("pulse_seq", first_sequence, 8'h00);
      check("pulse_res", first_result, 8'h00);
      goto(1855);
      check("re_res_1855", first_result, 8'h00);
      goto(1856);
      check("re_res_1856", first_result, EXP_RES);
      check("re_seq_1856", first_sequence, 8'hB4);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, errors);
      $finish;
   end

endmodule
